rf_seq: RTL and testbench

RF_SEQ -- requirements
Module: rf_seq

---
 rtl/rf_seq.sv | 185 ++++++++++++++++++
 tb/tb_rf_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_seq.sv
// Register-file sequencer: accepts one instruction at a time and drives the
// register-file strobes (enab/seg/mux_sel/reg_sel/or2_out) plus the ALU
// handshake. Every output comes straight from a flop.
module rf_seq #(
    parameter int unsigned ALU_TMO = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] op,
    input  logic [2:0] rd,
    input  logic [2:0] rs,
    input  logic [7:0] imm,
    input  logic       alu_done,
    output logic [1:0] enab,
    output logic [2:0] seg,
    output logic [2:0] mux_sel,
    output logic [2:0] reg_sel,
    output logic [7:0] or2_out,
    output logic       alu_start,
    output logic       rd_done,
    output logic       err
);

    localparam logic [2:0] OpNop = 3'b000;
    localparam logic [2:0] OpMov = 3'b001;
    localparam logic [2:0] OpMvi = 3'b010;
    localparam logic [2:0] OpAlu = 3'b011;
    localparam logic [2:0] OpRd  = 3'b100;

    localparam logic [1:0] EnIdle  = 2'b00;
    localparam logic [1:0] EnWrite = 2'b01;
    localparam logic [1:0] EnRead  = 2'b11;

    localparam logic [2:0] SelReg = 3'b001;
    localparam logic [2:0] SelOr2 = 3'b010;
    localparam logic [2:0] SelAlu = 3'b011;

    // Last WAIT-cycle count value before the timeout fires.
    localparam logic [7:0] TmoLast = 8'(ALU_TMO - 1);

    typedef enum logic [2:0] {StIdle, StWr, StRds, StWait, StWb} state_e;

    state_e     state_q, state_d;
    logic [1:0] enab_q, enab_d;
    logic [2:0] seg_q, seg_d;
    logic [2:0] mux_sel_q, mux_sel_d;
    logic [2:0] reg_sel_q, reg_sel_d;
    logic [7:0] or2_q, or2_d;
    logic       alu_start_q, alu_start_d;
    logic       rd_done_q, rd_done_d;
    logic       err_q, err_d;
    logic       ready_q, ready_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] rd_cap_q, rd_cap_d;
    logic       is_alu_q, is_alu_d;

    // Next-state and next-output decode; outputs are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        enab_d      = EnIdle;
        seg_d       = seg_q;
        mux_sel_d   = mux_sel_q;
        reg_sel_d   = reg_sel_q;
        or2_d       = or2_q;
        alu_start_d = 1'b0;
        rd_done_d   = 1'b0;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        rd_cap_d    = rd_cap_q;
        is_alu_d    = is_alu_q;

        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    rd_cap_d = rd;
                    is_alu_d = 1'b0;
                    case (op)
                        OpNop: ;
                        OpMov: begin
                            state_d   = StWr;
                            enab_d    = EnWrite;
                            mux_sel_d = SelReg;
                            reg_sel_d = rs;
                            seg_d     = rd;
                        end
                        OpMvi: begin
                            state_d   = StWr;
                            enab_d    = EnWrite;
                            mux_sel_d = SelOr2;
                            seg_d     = rd;
                            or2_d     = imm;
                        end
                        OpRd: begin
                            state_d   = StRds;
                            enab_d    = EnRead;
                            seg_d     = rs;
                            rd_done_d = 1'b1;
                        end
                        OpAlu: begin
                            state_d     = StRds;
                            enab_d      = EnRead;
                            seg_d       = rs;
                            alu_start_d = 1'b1;
                            is_alu_d    = 1'b1;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StWr: state_d = StIdle;
            StRds: begin
                if (is_alu_q) begin
                    state_d = StWait;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                // alu_done on the last counted cycle takes priority over the timeout.
                if (alu_done) begin
                    state_d   = StWb;
                    enab_d    = EnWrite;
                    mux_sel_d = SelAlu;
                    seg_d     = rd_cap_q;
                end else if (cnt_q == TmoLast) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWb: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StIdle);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            enab_q      <= EnIdle;
            seg_q       <= 3'd0;
            mux_sel_q   <= 3'd0;
            reg_sel_q   <= 3'd0;
            or2_q       <= 8'd0;
            alu_start_q <= 1'b0;
            rd_done_q   <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            cnt_q       <= 8'd0;
            rd_cap_q    <= 3'd0;
            is_alu_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            enab_q      <= enab_d;
            seg_q       <= seg_d;
            mux_sel_q   <= mux_sel_d;
            reg_sel_q   <= reg_sel_d;
            or2_q       <= or2_d;
            alu_start_q <= alu_start_d;
            rd_done_q   <= rd_done_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            cnt_q       <= cnt_d;
            rd_cap_q    <= rd_cap_d;
            is_alu_q    <= is_alu_d;
        end
    end

    assign instr_ready = ready_q;
    assign enab        = enab_q;
    assign seg         = seg_q;
    assign mux_sel     = mux_sel_q;
    assign reg_sel     = reg_sel_q;
    assign or2_out     = or2_q;
    assign alu_start   = alu_start_q;
    assign rd_done     = rd_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_rf_seq.sv
// Bench for rf_seq: directed table, hand-written corner sequences and random
// instruction streams checked cycle by cycle against a transaction model.
module tb_rf_seq;

    localparam int TMO = 16;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_MOV = 3'b001;
    localparam logic [2:0] OP_MVI = 3'b010;
    localparam logic [2:0] OP_ALU = 3'b011;
    localparam logic [2:0] OP_RD  = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] op = '0, rd = '0, rs = '0;
    logic [7:0] imm = '0;
    logic       alu_done = 1'b0;
    logic [1:0] enab;
    logic [2:0] seg, mux_sel, reg_sel;
    logic [7:0] or2_out;
    logic       alu_start, rd_done, err;

    rf_seq #(.ALU_TMO(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .op         (op),
        .rd         (rd),
        .rs         (rs),
        .imm        (imm),
        .alu_done   (alu_done),
        .enab       (enab),
        .seg        (seg),
        .mux_sel    (mux_sel),
        .reg_sel    (reg_sel),
        .or2_out    (or2_out),
        .alu_start  (alu_start),
        .rd_done    (rd_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] enab;
        logic [2:0] seg;
        logic [2:0] mux;
        logic [2:0] rsel;
        logic [7:0] or2;
        logic       start;
        logic       rdd;
        logic       err;
        logic       ready;
    } outs_t;

    typedef struct {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [7:0] imm;
        int         done_at;
        outs_t      exp_first;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Model: the values the register-file controls should be holding.
    logic [2:0] m_seg = '0, m_mux = '0, m_rsel = '0;
    logic [7:0] m_or2 = '0;
    outs_t      first_act;

    function automatic outs_t act();
        return outs_t'({enab, seg, mux_sel, reg_sel, or2_out, alu_start, rd_done, err,
                        instr_ready});
    endfunction

    function automatic outs_t mk(input logic [1:0] e, input logic st, input logic rdd,
                                 input logic er, input logic rdy);
        return outs_t'({e, m_seg, m_mux, m_rsel, m_or2, st, rdd, er, rdy});
    endfunction

    function automatic string fmt(input outs_t o);
        return $sformatf("enab=%b seg=%0d mux=%0d rsel=%0d or2=%h start=%b rdd=%b err=%b rdy=%b",
                         o.enab, o.seg, o.mux, o.rsel, o.or2, o.start, o.rdd, o.err, o.ready);
    endfunction

    task automatic chk_val(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got [%s] want [%s]", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic chk(input string name, input outs_t exp);
        chk_val(name, act(), exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance a cycle; scramble non-offered inputs and optionally toggle alu_done.
    task automatic nxt(input bit noise);
        step();
        op       = 3'($urandom);
        rd       = 3'($urandom);
        rs       = 3'($urandom);
        imm      = 8'($urandom);
        alu_done = noise ? 1'($urandom) : 1'b0;
    endtask

    // Offer one instruction in an IDLE cycle and check every cycle until IDLE again.
    // done_at: WAIT cycle (1-based) carrying alu_done; 0 means never.
    task automatic issue(input logic [2:0] o, input logic [2:0] rdv, input logic [2:0] rsv,
                         input logic [7:0] iv, input int done_at, input bit noise);
        instr_valid = 1'b1;
        op  = o;
        rd  = rdv;
        rs  = rsv;
        imm = iv;
        alu_done = noise ? 1'($urandom) : 1'b0;
        nxt(noise);
        instr_valid = 1'b0;
        first_act = act();
        case (o)
            OP_NOP: chk("nop_idle", mk(2'b00, 0, 0, 0, 1));
            OP_MOV, OP_MVI: begin
                m_seg = rdv;
                if (o == OP_MOV) begin
                    m_mux  = 3'b001;
                    m_rsel = rsv;
                end else begin
                    m_mux = 3'b010;
                    m_or2 = iv;
                end
                chk("wr_cycle", mk(2'b01, 0, 0, 0, 0));
                nxt(noise);
                chk("wr_then_idle", mk(2'b00, 0, 0, 0, 1));
            end
            OP_RD: begin
                m_seg = rsv;
                chk("rd_cycle", mk(2'b11, 0, 1, 0, 0));
                nxt(noise);
                chk("rd_then_idle", mk(2'b00, 0, 0, 0, 1));
            end
            OP_ALU: begin
                m_seg = rsv;
                chk("alu_rds", mk(2'b11, 1, 0, 0, 0));
                for (int k = 1; k <= TMO; k++) begin
                    nxt(1'b0);
                    alu_done = (k == done_at);
                    chk("alu_wait", mk(2'b00, 0, 0, 0, 0));
                    if (k == done_at) break;
                end
                nxt(noise);
                if (done_at >= 1 && done_at <= TMO) begin
                    m_seg = rdv;
                    m_mux = 3'b011;
                    chk("alu_wb", mk(2'b01, 0, 0, 0, 0));
                    nxt(noise);
                    chk("alu_wb_idle", mk(2'b00, 0, 0, 0, 1));
                end else begin
                    chk("alu_timeout", mk(2'b00, 0, 0, 1, 1));
                end
            end
            default: chk("illegal_err", mk(2'b00, 0, 0, 1, 1));
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vecs[0] = '{OP_MVI, 3'd2, 3'd0, 8'h05, 0,
                    outs_t'({2'b01, 3'd2, 3'd2, 3'd0, 8'h05, 4'b0000})};
        vecs[1] = '{OP_MOV, 3'd0, 3'd2, 8'h33, 0,
                    outs_t'({2'b01, 3'd0, 3'd1, 3'd2, 8'h05, 4'b0000})};
        vecs[2] = '{OP_RD, 3'd3, 3'd0, 8'h00, 0,
                    outs_t'({2'b11, 3'd0, 3'd1, 3'd2, 8'h05, 4'b0100})};
        vecs[3] = '{OP_ALU, 3'd0, 3'd7, 8'h00, 3,
                    outs_t'({2'b11, 3'd7, 3'd1, 3'd2, 8'h05, 4'b1000})};
        vecs[4] = '{OP_ALU, 3'd1, 3'd4, 8'h00, 0,
                    outs_t'({2'b11, 3'd4, 3'd3, 3'd2, 8'h05, 4'b1000})};
        vecs[5] = '{OP_ALU, 3'd6, 3'd5, 8'h00, TMO,
                    outs_t'({2'b11, 3'd5, 3'd3, 3'd2, 8'h05, 4'b1000})};
        vecs[6] = '{3'b110, 3'd3, 3'd3, 8'hEE, 0,
                    outs_t'({2'b00, 3'd6, 3'd3, 3'd2, 8'h05, 4'b0011})};
        vecs[7] = '{OP_NOP, 3'd1, 3'd1, 8'h11, 0,
                    outs_t'({2'b00, 3'd6, 3'd3, 3'd2, 8'h05, 4'b0001})};
        vecs[8] = '{OP_MVI, 3'd7, 3'd0, 8'hA5, 0,
                    outs_t'({2'b01, 3'd7, 3'd2, 3'd2, 8'hA5, 4'b0000})};

        // Reset values while rst_n is low.
        #12;
        chk("reset_values", mk(2'b00, 0, 0, 0, 1));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("after_release", mk(2'b00, 0, 0, 0, 1));

        // Directed table; model checks every cycle, table pins the first one.
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, vecs[i].done_at, 1'b0);
            chk_val($sformatf("table_first[%0d]", i), first_act, vecs[i].exp_first);
        end

        // instr_valid held through a MOV: re-accepted exactly 2 cycles later.
        instr_valid = 1'b1;
        op = OP_MOV; rd = 3'd1; rs = 3'd3;
        step();
        m_seg = 3'd1; m_mux = 3'b001; m_rsel = 3'd3;
        chk("b2b_wr1", mk(2'b01, 0, 0, 0, 0));
        step();
        chk("b2b_gap", mk(2'b00, 0, 0, 0, 1));
        step();
        chk("b2b_wr2", mk(2'b01, 0, 0, 0, 0));
        instr_valid = 1'b0;
        step();
        chk("b2b_idle", mk(2'b00, 0, 0, 0, 1));

        // Illegal opcode with valid held, then NOP offered: single err pulse.
        instr_valid = 1'b1;
        op = 3'b110; rd = 3'd2; rs = 3'd5; imm = 8'hFF;
        step();
        op = OP_NOP;
        chk("ill_err", mk(2'b00, 0, 0, 1, 1));
        step();
        chk("ill_once", mk(2'b00, 0, 0, 0, 1));
        instr_valid = 1'b0;

        // Reset dropped in WAIT, alu_done pulsed while low: no write-back.
        instr_valid = 1'b1;
        op = OP_ALU; rd = 3'd5; rs = 3'd4;
        step();
        instr_valid = 1'b0;
        m_seg = 3'd4;
        chk("rst_rds", mk(2'b11, 1, 0, 0, 0));
        step();
        chk("rst_wait1", mk(2'b00, 0, 0, 0, 0));
        step();
        chk("rst_wait2", mk(2'b00, 0, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        m_seg = '0; m_mux = '0; m_rsel = '0; m_or2 = '0;
        chk("rst_async", mk(2'b00, 0, 0, 0, 1));
        alu_done = 1'b1;
        step();
        chk("rst_hold", mk(2'b00, 0, 0, 0, 1));
        alu_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_no_wb", mk(2'b00, 0, 0, 0, 1));
        issue(OP_MOV, 3'd2, 3'd6, 8'h00, 0, 1'b0);

        // Random stream with alu_done noise outside WAIT.
        for (int n = 0; n < 80; n++) begin
            logic [2:0] o;
            int d;
            int gap;
            o = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TMO));
            issue(o, 3'($urandom), 3'($urandom), 8'($urandom), d, 1'b1);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                nxt(1'b1);
                chk("rand_gap_idle", mk(2'b00, 0, 0, 0, 1));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
